// File: rtl/obj_row_writer.sv
// obj_row_writer: upstream feeder of the OBJ scanline double buffer.
// On start it clears the back buffer, then takes sprite descriptors (in OAM
// priority order) over a valid/ready handshake. For each sprite it reads
// that sprite's row pixels from OBJ VRAM (fixed VRAM_LAT read latency) and
// issues one buffer write per opaque on-screen column.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start, line_in      one-cycle start pulse and line number to render
//   spr_*               descriptor handshake and fields (x, width, row
//                       address, 8bpp, palbank, prio, semi, hflip, last)
//   vram_re/addr/rdata  OBJ VRAM read port (data VRAM_LAT cycles after re)
//   row, wcol, wdata,   buffer row select, write column/data/enable,
//   we, clear,          clear strobe and palette mode of the written pixel
//   palettemode
//   done                one-cycle pulse when the line is complete
module obj_row_writer #(
  parameter int unsigned VRAM_LAT = 2,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        line_in,
  input  logic              spr_valid,
  output logic              spr_ready,
  input  logic              spr_last,
  input  logic [8:0]        spr_x,
  input  logic [6:0]        spr_width,
  input  logic [ADDR_W-1:0] spr_row_addr,
  input  logic              spr_8bpp,
  input  logic [3:0]        spr_palbank,
  input  logic [1:0]        spr_prio,
  input  logic              spr_semi,
  input  logic              spr_hflip,
  output logic              vram_re,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_rdata,
  output logic [7:0]        row,
  output logic [7:0]        wcol,
  output logic [19:0]       wdata,
  output logic              we,
  output logic              clear,
  output logic              palettemode,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SPR, FETCH, DRAIN} state_t;

  state_t state;

  // latched descriptor
  logic [8:0]        s_x;
  logic [6:0]        s_width;
  logic [ADDR_W-1:0] s_addr;
  logic              s_8bpp;
  logic [3:0]        s_pal;
  logic [1:0]        s_prio;
  logic              s_semi;
  logic              s_hflip;
  logic              s_last;

  logic [6:0] idx;
  logic [2:0] drain_cnt;

  // read-tag pipeline: stage 0 is the slot currently on the VRAM port,
  // stage VRAM_LAT lines up with the returning vram_rdata
  logic       pv [0:VRAM_LAT];
  logic [7:0] pc [0:VRAM_LAT];
  logic       pp [0:VRAM_LAT];

  assign vram_re = pv[0];

  // Read outputs are registered, so the slot for the next FETCH cycle is
  // computed one cycle ahead: from the incoming descriptor (column 0) when
  // accepting, otherwise from the latched fields (column idx+1).
  logic              accepting;
  logic [8:0]        sel_x;
  logic [5:0]        sel_w6;
  logic [ADDR_W-1:0] sel_base;
  logic              sel_8bpp;
  logic              sel_hflip;
  logic [5:0]        i6;
  logic [5:0]        p;
  logic [8:0]        n_off;
  logic [ADDR_W-1:0] n_addr;
  logic [8:0]        n_col;
  logic [3:0]        nib;
  logic [7:0]        color;
  logic              opaque;

  always_comb begin
    accepting = (state == WAIT_SPR);
    sel_x     = accepting ? spr_x             : s_x;
    sel_w6    = accepting ? spr_width[5:0]    : s_width[5:0];
    sel_base  = accepting ? spr_row_addr      : s_addr;
    sel_8bpp  = accepting ? spr_8bpp          : s_8bpp;
    sel_hflip = accepting ? spr_hflip         : s_hflip;
    i6        = accepting ? 6'd0 : idx[5:0] + 6'd1;
    // width 64 wraps to 0 in six bits, which still gives 63-i
    p         = sel_hflip ? (sel_w6 - 6'd1 - i6) : i6;
    n_off     = sel_8bpp ? {p[5:3], 3'b000, p[2:0]}          // tile*64 + px
                         : {1'b0, p[5:3], 3'b000, p[2:1]};   // tile*32 + px/2
    n_addr    = sel_base + ADDR_W'(n_off);
    n_col     = sel_x + {3'b000, i6};

    nib    = pp[VRAM_LAT] ? vram_rdata[7:4] : vram_rdata[3:0];
    color  = s_8bpp ? vram_rdata : {s_pal, nib};
    opaque = s_8bpp ? (|vram_rdata) : (|nib);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      spr_ready   <= 1'b0;
      vram_addr   <= '0;
      row         <= '0;
      wcol        <= '0;
      wdata       <= '0;
      we          <= 1'b0;
      clear       <= 1'b0;
      palettemode <= 1'b0;
      done        <= 1'b0;
      s_x         <= '0;
      s_width     <= '0;
      s_addr      <= '0;
      s_8bpp      <= 1'b0;
      s_pal       <= '0;
      s_prio      <= '0;
      s_semi      <= 1'b0;
      s_hflip     <= 1'b0;
      s_last      <= 1'b0;
      idx         <= '0;
      drain_cnt   <= '0;
      for (int unsigned k = 0; k <= VRAM_LAT; k++) begin
        pv[k] <= 1'b0;
        pc[k] <= '0;
        pp[k] <= 1'b0;
      end
    end else begin
      done  <= 1'b0;
      clear <= 1'b0;

      for (int unsigned k = 1; k <= VRAM_LAT; k++) begin
        pv[k] <= pv[k-1];
        pc[k] <= pc[k-1];
        pp[k] <= pp[k-1];
      end
      pv[0] <= 1'b0;

      // write stage
      we <= pv[VRAM_LAT] && opaque;
      if (pv[VRAM_LAT]) begin
        wcol        <= pc[VRAM_LAT];
        wdata       <= {5'b00000, s_semi, 4'b0000, s_prio, color};
        palettemode <= s_8bpp;
      end

      case (state)
        IDLE: begin
          if (start) begin
            row   <= line_in;
            clear <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          spr_ready <= 1'b1;
          state     <= WAIT_SPR;
        end
        WAIT_SPR: begin
          if (spr_valid) begin
            s_x       <= spr_x;
            s_width   <= spr_width;
            s_addr    <= spr_row_addr;
            s_8bpp    <= spr_8bpp;
            s_pal     <= spr_palbank;
            s_prio    <= spr_prio;
            s_semi    <= spr_semi;
            s_hflip   <= spr_hflip;
            s_last    <= spr_last;
            spr_ready <= 1'b0;
            idx       <= '0;
            drain_cnt <= '0;
            if (spr_width == 7'd0) begin
              state <= DRAIN;
            end else begin
              state     <= FETCH;
              pv[0]     <= (n_col < 9'd240);
              pc[0]     <= n_col[7:0];
              pp[0]     <= p[0];
              vram_addr <= n_addr;
            end
          end
        end
        FETCH: begin
          if (idx == s_width - 7'd1) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            idx       <= idx + 7'd1;
            pv[0]     <= (n_col < 9'd240);
            pc[0]     <= n_col[7:0];
            pp[0]     <= p[0];
            vram_addr <= n_addr;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'(VRAM_LAT)) begin
            if (s_last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              spr_ready <= 1'b1;
              state     <= WAIT_SPR;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_row_writer.sv
module tb_obj_row_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  line_in;
  logic        spr_valid;
  logic        spr_ready;
  logic        spr_last;
  logic [8:0]  spr_x;
  logic [6:0]  spr_width;
  logic [14:0] spr_row_addr;
  logic        spr_8bpp;
  logic [3:0]  spr_palbank;
  logic [1:0]  spr_prio;
  logic        spr_semi;
  logic        spr_hflip;
  logic        vram_re;
  logic [14:0] vram_addr;
  logic [7:0]  vram_rdata;
  logic [7:0]  row;
  logic [7:0]  wcol;
  logic [19:0] wdata;
  logic        we;
  logic        clear;
  logic        palettemode;
  logic        done;

  obj_row_writer #(.VRAM_LAT(2), .ADDR_W(15)) dut (
    .clock(clock), .reset(reset), .start(start), .line_in(line_in),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_last(spr_last),
    .spr_x(spr_x), .spr_width(spr_width), .spr_row_addr(spr_row_addr),
    .spr_8bpp(spr_8bpp), .spr_palbank(spr_palbank), .spr_prio(spr_prio),
    .spr_semi(spr_semi), .spr_hflip(spr_hflip),
    .vram_re(vram_re), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .row(row), .wcol(wcol), .wdata(wdata), .we(we), .clear(clear),
    .palettemode(palettemode), .done(done)
  );

  always #5 clock = ~clock;

  // VRAM model: two-cycle latency, 0xEE on cycles with no request
  logic [7:0]  mem [0:32767];
  logic [14:0] a1;
  logic        r1;
  always @(posedge clock) begin
    a1         <= vram_addr;
    r1         <= vram_re;
    vram_rdata <= r1 ? mem[a1] : 8'hEE;
  end

  // activity logs
  logic [14:0] rd_q[$];
  logic [28:0] wr_q[$];
  logic [14:0] exp_rd[$];
  logic [28:0] exp_wr[$];
  int done_cnt = 0;
  int inv_bad  = 0;

  always @(negedge clock) begin
    if (vram_re) rd_q.push_back(vram_addr);
    if (we) wr_q.push_back({palettemode, wcol, wdata});
    if (clear && we) inv_bad++;
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size(); k++)
      check($sformatf("%s_rd%0d", tag, k),
            (k < rd_q.size()) ? 32'(rd_q[k]) : 32'hFFFF_FFFF, 32'(exp_rd[k]));
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size(); k++)
      check($sformatf("%s_wr%0d", tag, k),
            (k < wr_q.size()) ? 32'(wr_q[k]) : 32'hFFFF_FFFF, 32'(exp_wr[k]));
    rd_q.delete(); wr_q.delete(); exp_rd.delete(); exp_wr.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_spr(input logic [8:0] x, input logic [6:0] w, input logic [14:0] base,
                         input logic b8, input logic [3:0] pal, input logic [1:0] prio,
                         input logic semi, input logic hf, input logic last);
    spr_x = x; spr_width = w; spr_row_addr = base; spr_8bpp = b8;
    spr_palbank = pal; spr_prio = prio; spr_semi = semi; spr_hflip = hf;
    spr_last = last;
  endtask

  int c;

  initial begin
    for (int k = 0; k < 32768; k++) mem[k] = 8'h00;
    for (int k = 0; k < 4; k++) mem[15'h100 + k] = 8'h21;
    mem[15'h200] = 8'h43; mem[15'h201] = 8'h05; mem[15'h202] = 8'h76; mem[15'h203] = 8'h98;
    for (int k = 0; k < 8; k++) begin
      mem[15'h1000 + k] = 8'h80 + 8'(k);
      mem[15'h1040 + k] = 8'hC0 + 8'(k);
    end
    mem[15'h322] = 8'h21; mem[15'h323] = 8'h43;

    reset = 1'b1; start = 1'b0; line_in = '0; spr_valid = 1'b0;
    set_spr(9'd0, 7'd0, 15'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("por_ctrl", 32'({spr_ready, vram_re, we, clear, palettemode, done}), 32'h0);
    check("por_row", 32'(row), 32'h0);
    reset = 1'b0;
    tick();
    rd_q.delete(); wr_q.delete();

    // single 4bpp sprite, line 5
    set_spr(9'd10, 7'd8, 15'h100, 1'b0, 4'h3, 2'd0, 1'b0, 1'b0, 1'b1);
    spr_valid = 1'b1; start = 1'b1; line_in = 8'd5;
    tick();
    start = 1'b0;
    check("s1_clear", 32'({clear, we, spr_ready}), 32'b100);
    check("s1_row", 32'(row), 32'd5);
    tick();
    check("s1_ready", 32'(spr_ready), 32'd1);
    tick();
    spr_valid = 1'b0;
    check("s1_first_rd", 32'({vram_re, vram_addr}), 32'({1'b1, 15'h100}));
    c = 1;
    while (!done && c < 60) begin tick(); c++; end
    check("s1_done_cyc", 32'(c), 32'd12);
    tick();
    check("s1_done_pulse", 32'({done, spr_ready}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      exp_rd.push_back(15'h100 + 15'(k / 2));
      exp_wr.push_back({1'b0, 8'(10 + k), (k % 2 == 0) ? 20'h00031 : 20'h00032});
    end
    compare_logs("s1");

    // two sprites back-to-back, spr_valid held, stray start in FETCH
    done_cnt = 0;
    set_spr(9'd20, 7'd8, 15'h200, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0, 1'b0);
    spr_valid = 1'b1; start = 1'b1; line_in = 8'd9;
    tick();
    start = 1'b0;
    tick();
    check("s2_ready_a", 32'(spr_ready), 32'd1);
    tick();
    set_spr(9'd0, 7'd16, 15'h1000, 1'b1, 4'h0, 2'd2, 1'b1, 1'b1, 1'b1);
    tick();
    start = 1'b1; line_in = 8'd99;
    tick();
    start = 1'b0;
    c = 3;
    while (!spr_ready && c < 60) begin tick(); c++; end
    check("s2_accept_b_cyc", 32'(c), 32'd12);
    tick(); c++;
    spr_valid = 1'b0;
    while (!done && c < 120) begin tick(); c++; end
    check("s2_done_cyc", 32'(c), 32'd32);
    check("s2_row", 32'(row), 32'd9);
    tick(); tick(); tick();
    check("s2_done_cnt", 32'(done_cnt), 32'd1);
    for (int k = 0; k < 8; k++) exp_rd.push_back(15'h200 + 15'(k / 2));
    exp_wr.push_back({1'b0, 8'd20, 20'h001A3});
    exp_wr.push_back({1'b0, 8'd21, 20'h001A4});
    exp_wr.push_back({1'b0, 8'd22, 20'h001A5});
    exp_wr.push_back({1'b0, 8'd24, 20'h001A6});
    exp_wr.push_back({1'b0, 8'd25, 20'h001A7});
    exp_wr.push_back({1'b0, 8'd26, 20'h001A8});
    exp_wr.push_back({1'b0, 8'd27, 20'h001A9});
    for (int k = 0; k < 16; k++) begin
      exp_rd.push_back((k < 8) ? 15'h1047 - 15'(k) : 15'h100F - 15'(k));
      exp_wr.push_back({1'b1, 8'(k),
                        20'h04200 | 20'((k < 8) ? 8'hC7 - 8'(k) : 8'h8F - 8'(k))});
    end
    compare_logs("s2");

    // reset in the middle of FETCH
    set_spr(9'd0, 7'd8, 15'h100, 1'b0, 4'h3, 2'd0, 1'b0, 1'b0, 1'b1);
    spr_valid = 1'b1; start = 1'b1; line_in = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    spr_valid = 1'b0;
    tick(); tick();
    check("r_pre_re", 32'(vram_re), 32'd1);
    reset = 1'b1;
    tick();
    check("r_ctrl", 32'({spr_ready, vram_re, we, clear, palettemode, done}), 32'h0);
    check("r_addr", 32'(vram_addr), 32'h0);
    check("r_row_wcol", 32'({row, wcol}), 32'h0);
    check("r_wdata", 32'(wdata), 32'h0);
    reset = 1'b0;
    rd_q.delete(); wr_q.delete();
    tick(); tick(); tick(); tick(); tick();
    check("r_idle", 32'({spr_ready, done}), 32'd0);
    compare_logs("r");

    // sprite straddling the right edge: x=500, w=16
    set_spr(9'd500, 7'd16, 15'h300, 1'b0, 4'h5, 2'd3, 1'b0, 1'b0, 1'b1);
    spr_valid = 1'b1; start = 1'b1; line_in = 8'd40;
    tick();
    start = 1'b0;
    tick();
    tick();
    spr_valid = 1'b0;
    check("w_row", 32'(row), 32'd40);
    c = 1;
    while (!done && c < 60) begin tick(); c++; end
    check("w_done_cyc", 32'(c), 32'd20);
    exp_rd.push_back(15'h322); exp_rd.push_back(15'h322);
    exp_rd.push_back(15'h323); exp_rd.push_back(15'h323);
    exp_wr.push_back({1'b0, 8'd0, 20'h00351});
    exp_wr.push_back({1'b0, 8'd1, 20'h00352});
    exp_wr.push_back({1'b0, 8'd2, 20'h00353});
    exp_wr.push_back({1'b0, 8'd3, 20'h00354});
    compare_logs("w");

    // null last descriptor
    set_spr(9'd0, 7'd0, 15'h100, 1'b0, 4'h1, 2'd0, 1'b0, 1'b0, 1'b1);
    spr_valid = 1'b1; start = 1'b1; line_in = 8'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    spr_valid = 1'b0;
    c = 1;
    while (!done && c < 40) begin tick(); c++; end
    check("z_done_cyc", 32'(c), 32'd4);
    tick(); tick(); tick();
    compare_logs("z");

    check("inv_clear_we", 32'(inv_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
